// File: rtl/jpeg_spi_slave_if.sv
// jpeg_spi_slave_if
// SPI mode-0 slave (MSB first) sitting behind the JPEG byte streamer.
// sclk/cs_n/mosi are oversampled in the clk domain; a command byte selects
// between streaming encoded bytes (rd_req/rd_data prefetch), returning a
// status byte, or ignoring the rest of the transaction.
//
// Streamer handshake: rd_req is a one-clk request pulse with no back-pressure.
// rd_data is valid from the clk after rd_req and is held by the streamer until
// the next rd_req; this block captures it two clk after the pulse.
//
// dbg_state_o encoding: 0 IDLE, 1 CMD, 2 STREAM, 3 STATUS, 4 IGNORE.
module jpeg_spi_slave_if #(
   parameter logic [7:0] CMD_READ    = 8'h03,
   parameter logic [7:0] CMD_STATUS  = 8'h05,
   parameter int         SYNC_STAGES = 2,
   parameter int         CNT_W       = 17
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             sclk,
   input  logic             cs_n,
   input  logic             mosi,
   output logic             miso,
   output logic             rd_req,
   input  logic [7:0]       rd_data,
   input  logic             je_done,
   output logic             data_ready,
   output logic [CNT_W-1:0] byte_cnt,
   output logic [2:0]       dbg_state_o
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CMD    = 3'd1,
      ST_STREAM = 3'd2,
      ST_STATUS = 3'd3,
      ST_IGNORE = 3'd4
   } state_t;

   // ------------------------------------------------------------------
   // Input synchronisers plus one history flop per signal
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sclk_sync_q;
   logic [SYNC_STAGES-1:0] cs_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic                   sclk_hist_q;
   logic                   cs_hist_q;
   logic                   mosi_hist_q;

   logic sclk_s;
   logic cs_s;
   logic sclk_rise;
   logic sclk_fall;
   logic cs_fall;
   logic mosi_bit;

   // Shift the asynchronous pins through the synchroniser chains. The cs_n
   // chain resets to "selected" so that a cs_n already held low at reset
   // release never looks like a fresh fall; it must go high first.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sclk_sync_q <= '0;
         cs_sync_q   <= '0;
         mosi_sync_q <= '0;
         sclk_hist_q <= 1'b0;
         cs_hist_q   <= 1'b0;
         mosi_hist_q <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
         sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
         cs_hist_q   <= cs_sync_q[SYNC_STAGES-1];
         mosi_hist_q <= mosi_sync_q[SYNC_STAGES-1];
      end
   end

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_hist_q;
   assign sclk_fall = ~sclk_s & sclk_hist_q;
   assign cs_fall   = ~cs_s & cs_hist_q;
   // mosi is stable across the whole sclk low phase, so the copy one clk
   // older than the sclk edge detector is a safe sample point.
   assign mosi_bit  = mosi_hist_q;

   // ------------------------------------------------------------------
   // Protocol state
   // ------------------------------------------------------------------
   state_t           state_q, state_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [6:0]       rx_sr_q, rx_sr_d;
   logic [7:0]       tx_sr_q, tx_sr_d;
   logic             miso_q, miso_d;
   logic             rd_req_q, rd_req_d;
   logic             load_q, load_d;
   logic             data_ready_q, data_ready_d;
   logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
   logic [7:0]       rx_byte;
   logic             clr_ready;

   // Next-state, shift-register and output decode for the SPI FSM.
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      rx_sr_d      = rx_sr_q;
      tx_sr_d      = tx_sr_q;
      miso_d       = miso_q;
      rd_req_d     = 1'b0;
      load_d       = rd_req_q;
      byte_cnt_d   = byte_cnt_q;
      clr_ready    = 1'b0;
      data_ready_d = data_ready_q;
      rx_byte      = {rx_sr_q, mosi_bit};

      case (state_q)
         ST_IDLE: begin
            miso_d    = 1'b0;
            tx_sr_d   = '0;
            bit_cnt_d = '0;
            if (cs_fall) begin
               state_d    = ST_CMD;
               rx_sr_d    = '0;
               byte_cnt_d = '0;
            end
         end

         ST_CMD: begin
            if (sclk_rise) begin
               bit_cnt_d = bit_cnt_q + 3'd1;
               rx_sr_d   = rx_byte[6:0];
               if (bit_cnt_q == 3'd7) begin
                  if (rx_byte == CMD_READ) begin
                     state_d  = ST_STREAM;
                     rd_req_d = 1'b1;
                  end else if (rx_byte == CMD_STATUS) begin
                     state_d = ST_STATUS;
                     tx_sr_d = {7'b0, data_ready_q};
                  end else begin
                     state_d = ST_IGNORE;
                  end
               end
            end
         end

         ST_STREAM: begin
            if (sclk_rise) begin
               bit_cnt_d = bit_cnt_q + 3'd1;
               // Byte boundary: count it and prefetch the following byte.
               if (bit_cnt_q == 3'd7) begin
                  if (byte_cnt_q != '1) begin
                     byte_cnt_d = byte_cnt_q + 1'b1;
                  end
                  rd_req_d = 1'b1;
               end
            end
            if (sclk_fall) begin
               miso_d  = tx_sr_q[7];
               tx_sr_d = {tx_sr_q[6:0], 1'b0};
            end
            if (load_q) begin
               tx_sr_d = rd_data;
            end
         end

         ST_STATUS: begin
            if (sclk_rise) begin
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  tx_sr_d = {7'b0, data_ready_q};
               end
            end
            if (sclk_fall) begin
               miso_d  = tx_sr_q[7];
               tx_sr_d = {tx_sr_q[6:0], 1'b0};
            end
         end

         ST_IGNORE: begin
            miso_d = 1'b0;
            if (sclk_rise) begin
               bit_cnt_d = bit_cnt_q + 3'd1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Deselect aborts from any state; a partial byte is simply dropped
      // and an already-issued prefetch is left consumed.
      if (cs_s && (state_q != ST_IDLE)) begin
         state_d   = ST_IDLE;
         miso_d    = 1'b0;
         tx_sr_d   = '0;
         bit_cnt_d = '0;
         if ((state_q == ST_STREAM) && (byte_cnt_d != '0)) begin
            clr_ready = 1'b1;
         end
      end

      // A frame announced in the same clk as the clear must not be lost.
      if (je_done) begin
         data_ready_d = 1'b1;
      end else if (clr_ready) begin
         data_ready_d = 1'b0;
      end
   end

   // Register the FSM state, shift registers, counters and outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         bit_cnt_q    <= '0;
         rx_sr_q      <= '0;
         tx_sr_q      <= '0;
         miso_q       <= 1'b0;
         rd_req_q     <= 1'b0;
         load_q       <= 1'b0;
         data_ready_q <= 1'b0;
         byte_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         rx_sr_q      <= rx_sr_d;
         tx_sr_q      <= tx_sr_d;
         miso_q       <= miso_d;
         rd_req_q     <= rd_req_d;
         load_q       <= load_d;
         data_ready_q <= data_ready_d;
         byte_cnt_q   <= byte_cnt_d;
      end
   end

   assign miso        = miso_q;
   assign rd_req      = rd_req_q;
   assign data_ready  = data_ready_q;
   assign byte_cnt    = byte_cnt_q;
   assign dbg_state_o = state_q;

endmodule
